sample_recorder: RTL and testbench

//  Capture-side counterpart of the ROM/PWM playback path: records a burst of audio

---
 rtl/sample_recorder.sv | 156 +++++++++++++++
 tb/tb_sample_recorder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_recorder.sv
// sample_recorder: records a triggered burst of audio samples into an internal
// sample RAM at the sample rate. The take arms on a rec_en rising edge, starts
// when |sample| reaches THRESH and stops when the RAM is full or rec_en drops.
// A registered read port serves the playback path in every state.
module sample_recorder #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 10,
  parameter logic [DATA_W-1:0] THRESH = 16'h0400
) (
  input  logic              clkdived_data,
  input  logic              rstn,
  input  logic              rec_en,
  input  logic [DATA_W-1:0] smp_i,
  input  logic              smp_valid_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic [1:0]        state_o,
  output logic              full_o,
  output logic              overrun_o
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RECORD = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Sample storage: no reset so it maps onto block RAM and survives a reset.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  logic              rec_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   wr_count_q;
  logic              full_q;
  logic              overrun_q;
  logic [DATA_W-1:0] rd_q;

  logic              rise_d;
  logic [DATA_W:0]   smp_ext_d;
  logic [DATA_W:0]   abs_d;
  logic              trig_d;
  logic [ADDR_W:0]   count_inc_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;

  // Edge detect, magnitude (one extra bit so the most negative code does not
  // overflow), trigger compare and RAM write controls.
  always_comb begin
    rise_d      = rec_en & ~rec_en_q;
    smp_ext_d   = {smp_i[DATA_W-1], smp_i};
    abs_d       = smp_ext_d[DATA_W] ? -smp_ext_d : smp_ext_d;
    trig_d      = abs_d >= {1'b0, THRESH};
    count_inc_d = wr_count_q + (ADDR_W+1)'(1);
    // The trigger sample always lands at address 0; during RECORD every valid
    // sample is written, including one arriving in the cycle rec_en drops.
    we_d        = smp_valid_i &
                  (((state_q == ST_ARMED) & rec_en & trig_d) |
                   (state_q == ST_RECORD));
    waddr_d     = (state_q == ST_ARMED) ? '0 : wr_addr_q;
  end

  // Take control FSM with registered status outputs.
  always_ff @(posedge clkdived_data or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rec_en_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rec_en_q <= rec_en;
      case (state_q)
        ST_IDLE: begin
          if (rise_d) begin
            state_q    <= ST_ARMED;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (!rec_en) begin
            state_q <= ST_IDLE;
          end else if (smp_valid_i && trig_d) begin
            // Counters are zero here, so this is the first write of the take.
            wr_addr_q  <= wr_addr_q + ADDR_W'(1);
            wr_count_q <= count_inc_d;
            if (count_inc_d == DEPTH_CNT) begin
              state_q <= ST_DONE;
              full_q  <= 1'b1;
            end else begin
              state_q <= ST_RECORD;
            end
          end
        end
        ST_RECORD: begin
          if (smp_valid_i) begin
            wr_addr_q  <= wr_addr_q + ADDR_W'(1);
            wr_count_q <= count_inc_d;
            if (count_inc_d == DEPTH_CNT) begin
              state_q <= ST_DONE;
              full_q  <= 1'b1;
            end
          end
          // Truncated take: the count keeps whatever was stored.
          if (!rec_en) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rise_d) begin
            state_q    <= ST_ARMED;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
          end else if (smp_valid_i && full_q) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Single RAM write port.
  always_ff @(posedge clkdived_data) begin
    if (we_d) begin
      mem[waddr_d] <= smp_i;
    end
  end

  // Registered read port; sees pre-write contents on an address collision.
  always_ff @(posedge clkdived_data or negedge rstn) begin
    if (!rstn) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o  = 32'(rd_q);
  assign wr_count_o = wr_count_q;
  assign state_o    = state_q;
  assign full_o     = full_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Testbench for sample_recorder: directed scenarios plus randomized takes,
// checked against a queue/array model of what each take should have stored.
module tb_sample_recorder;

  logic        clk;
  logic        rstn;
  logic        rec_en;
  logic [15:0] smp_i;
  logic        smp_valid_i;
  logic [9:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic [10:0] wr_count_o;
  logic [1:0]  state_o;
  logic        full_o;
  logic        overrun_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model of RAM contents as the recorder should have left them.
  logic [15:0] ref_mem [1024];

  sample_recorder dut (
    .clkdived_data(clk),
    .rstn        (rstn),
    .rec_en      (rec_en),
    .smp_i       (smp_i),
    .smp_valid_i (smp_valid_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .wr_count_o  (wr_count_o),
    .state_o     (state_o),
    .full_o      (full_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int absval(input logic [15:0] v);
    int u;
    u = int'(v);
    return v[15] ? 65536 - u : u;
  endfunction

  task automatic rd_word(input int a, output logic [31:0] d);
    rd_addr_i = 10'(a);
    tick();
    d = rd_data_o;
  endtask

  // Re-arm: rec_en low for a cycle, then a rising edge.
  task automatic arm();
    smp_valid_i = 1'b0;
    rec_en = 1'b0;
    tick();
    rec_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; rec_en = 1'b0; smp_i = '0; smp_valid_i = 1'b0; rd_addr_i = '0;
    tick(); tick();
    total_cnt++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else pass_cnt++;
    total_cnt++; if (wr_count_o !== 11'd0) $display("FAIL reset_count: got %0d want 0", wr_count_o); else pass_cnt++;
    total_cnt++; if (rd_data_o !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rd_data_o); else pass_cnt++;
    total_cnt++; if (full_o !== 1'b0 || overrun_o !== 1'b0)
      $display("FAIL reset_flags: got full=%b ovr=%b want 0 0", full_o, overrun_o); else pass_cnt++;
    rstn = 1'b1;
    tick();
    $display("reset released: state=%0d count=%0d", state_o, wr_count_o);
  endtask

  task automatic test_arm();
    logic [15:0] sub [4];
    sub[0] = 16'h0010; sub[1] = 16'h0100; sub[2] = 16'h03FF; sub[3] = 16'hFC01;
    arm();
    for (int i = 0; i < 4; i++) begin
      smp_i = sub[i]; smp_valid_i = 1'b1;
      tick();
      $display("armed sample %h: state=%0d count=%0d", sub[i], state_o, wr_count_o);
    end
    smp_valid_i = 1'b0;
    total_cnt++; if (state_o !== 2'd1) $display("FAIL arm_state: got %0d want 1", state_o); else pass_cnt++;
    total_cnt++; if (wr_count_o !== 11'd0) $display("FAIL arm_count: got %0d want 0", wr_count_o); else pass_cnt++;
  endtask

  task automatic test_trigger();
    logic [31:0] d;
    smp_i = 16'h0400; smp_valid_i = 1'b1;
    tick();
    smp_valid_i = 1'b0;
    ref_mem[0] = 16'h0400;
    total_cnt++; if (state_o !== 2'd2) $display("FAIL trig_state: got %0d want 2", state_o); else pass_cnt++;
    total_cnt++; if (wr_count_o !== 11'd1) $display("FAIL trig_count: got %0d want 1", wr_count_o); else pass_cnt++;
    rd_word(0, d);
    $display("trigger 0x0400: rd_data=%h", d);
    total_cnt++; if (d !== 32'h0000_0400) $display("FAIL trig_rdata: got %h want 00000400", d); else pass_cnt++;
  endtask

  task automatic test_neg_trigger();
    logic [31:0] d;
    rec_en = 1'b0;
    tick();
    total_cnt++; if (state_o !== 2'd3 || wr_count_o !== 11'd1)
      $display("FAIL trunc1_state: got st=%0d cnt=%0d want 3 1", state_o, wr_count_o); else pass_cnt++;
    arm();
    smp_i = 16'h8000; smp_valid_i = 1'b1;
    tick();
    smp_valid_i = 1'b0;
    ref_mem[0] = 16'h8000;
    total_cnt++; if (state_o !== 2'd2 || wr_count_o !== 11'd1)
      $display("FAIL neg_trig: got st=%0d cnt=%0d want 2 1", state_o, wr_count_o); else pass_cnt++;
    rd_word(0, d);
    $display("trigger 0x8000: rd_data=%h", d);
    total_cnt++; if (d !== 32'h0000_8000) $display("FAIL neg_rdata: got %h want 00008000", d); else pass_cnt++;
    rec_en = 1'b0;
    tick();
  endtask

  task automatic test_full_overrun();
    logic [31:0] d;
    int a;
    arm();
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        smp_i = 16'($urandom); smp_valid_i = 1'b0;
        tick();
      end
      if (i == 1023) begin
        total_cnt++; if (state_o !== 2'd2 || wr_count_o !== 11'd1023 || full_o !== 1'b0)
          $display("FAIL pre_full: got st=%0d cnt=%0d full=%b want 2 1023 0", state_o, wr_count_o, full_o);
        else pass_cnt++;
      end
      smp_i = 16'(16'h0400 + i); smp_valid_i = 1'b1;
      ref_mem[i] = 16'(16'h0400 + i);
      tick();
    end
    $display("ramp done: state=%0d count=%0d full=%b", state_o, wr_count_o, full_o);
    total_cnt++; if (state_o !== 2'd3) $display("FAIL full_state: got %0d want 3", state_o); else pass_cnt++;
    total_cnt++; if (wr_count_o !== 11'd1024) $display("FAIL full_count: got %0d want 1024", wr_count_o); else pass_cnt++;
    total_cnt++; if (full_o !== 1'b1 || overrun_o !== 1'b0)
      $display("FAIL full_flag: got full=%b ovr=%b want 1 0", full_o, overrun_o); else pass_cnt++;
    smp_i = 16'h1234; smp_valid_i = 1'b1;
    tick();
    smp_valid_i = 1'b0;
    $display("extra sample: overrun=%b count=%0d", overrun_o, wr_count_o);
    total_cnt++; if (overrun_o !== 1'b1 || wr_count_o !== 11'd1024 || state_o !== 2'd3)
      $display("FAIL overrun: got ovr=%b cnt=%0d st=%0d want 1 1024 3", overrun_o, wr_count_o, state_o);
    else pass_cnt++;
    tick();
    total_cnt++; if (overrun_o !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun_o); else pass_cnt++;
    rd_word(0, d);
    total_cnt++; if (d !== 32'h0000_0400) $display("FAIL full_mem0: got %h want 00000400", d); else pass_cnt++;
    rd_word(1023, d);
    total_cnt++; if (d !== 32'h0000_07FF) $display("FAIL full_mem1023: got %h want 000007ff", d); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, 1023);
      rd_word(a, d);
      total_cnt++; if (d !== 32'(ref_mem[a])) $display("FAIL full_mem_rand[%0d]: got %h want %h", a, d, ref_mem[a]);
      else pass_cnt++;
    end
  endtask

  task automatic test_truncate();
    logic [31:0] d;
    logic [15:0] v;
    arm();
    total_cnt++; if (state_o !== 2'd1 || wr_count_o !== 11'd0 || full_o !== 1'b0 || overrun_o !== 1'b0)
      $display("FAIL rearm_clear: got st=%0d cnt=%0d full=%b ovr=%b want 1 0 0 0", state_o, wr_count_o, full_o, overrun_o);
    else pass_cnt++;
    for (int i = 0; i < 37; i++) begin
      v = (i == 0) ? 16'h0500 : 16'($urandom);
      smp_i = v; smp_valid_i = 1'b1;
      rec_en = (i != 36);
      ref_mem[i] = v;
      tick();
    end
    smp_valid_i = 1'b0;
    $display("truncated take: state=%0d count=%0d full=%b", state_o, wr_count_o, full_o);
    total_cnt++; if (state_o !== 2'd3 || wr_count_o !== 11'd37 || full_o !== 1'b0)
      $display("FAIL truncate: got st=%0d cnt=%0d full=%b want 3 37 0", state_o, wr_count_o, full_o);
    else pass_cnt++;
    rd_word(36, d);
    total_cnt++; if (d !== 32'(ref_mem[36])) $display("FAIL trunc_last: got %h want %h", d, ref_mem[36]); else pass_cnt++;
    rd_word(37, d);
    total_cnt++; if (d !== 32'h0000_0425) $display("FAIL trunc_beyond: got %h want 00000425", d); else pass_cnt++;
    rec_en = 1'b1;
    tick();
    total_cnt++; if (state_o !== 2'd1 || wr_count_o !== 11'd0)
      $display("FAIL trunc_rearm: got st=%0d cnt=%0d want 1 0", state_o, wr_count_o); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic [31:0] d;
    logic [15:0] v;
    logic        vld;
    logic        trig;
    int          ncyc;
    int          errs;
    for (int take = 0; take < 6; take++) begin
      arm();
      q.delete();
      trig = 1'b0;
      ncyc = $urandom_range(5, 250);
      for (int c = 0; c < ncyc; c++) begin
        vld = ($urandom_range(0, 2) != 0);
        if (!trig && $urandom_range(0, 3) != 0) begin
          v = 16'($urandom_range(0, 16'h03FF));
          if ($urandom_range(0, 1) == 1) v = 16'(-v);
        end else begin
          v = 16'($urandom);
        end
        rec_en = (c != ncyc - 1);
        smp_i = v; smp_valid_i = vld;
        if (!trig) begin
          if (rec_en && vld && absval(v) >= 1024) begin
            trig = 1'b1;
            q.push_back(v);
          end
        end else if (vld) begin
          q.push_back(v);
        end
        tick();
      end
      smp_valid_i = 1'b0;
      for (int i = 0; i < q.size(); i++) ref_mem[i] = q[i];
      $display("random take %0d: cycles=%0d stored=%0d state=%0d count=%0d", take, ncyc, q.size(), state_o, wr_count_o);
      total_cnt++; if (state_o !== (trig ? 2'd3 : 2'd0) || wr_count_o !== 11'(q.size()) || full_o !== 1'b0)
        $display("FAIL rand_status[%0d]: got st=%0d cnt=%0d full=%b want %0d %0d 0",
                 take, state_o, wr_count_o, full_o, trig ? 3 : 0, q.size());
      else pass_cnt++;
      errs = 0;
      for (int i = 0; i < q.size(); i++) begin
        rd_word(i, d);
        total_cnt++;
        if (d !== 32'(q[i])) begin
          errs++;
          if (errs <= 4) $display("FAIL rand_mem[%0d][%0d]: got %h want %h", take, i, d, q[i]);
        end else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [15:0] v;
    logic [15:0] old400;
    int          errs;
    old400 = ref_mem[400];
    arm();
    for (int i = 0; i < 500; i++) begin
      v = (i == 0) ? 16'hC000 : 16'($urandom);
      smp_i = v; smp_valid_i = 1'b1;
      rd_addr_i = 10'd400;
      ref_mem[i] = v;
      tick();
      if (i == 400) begin
        total_cnt++; if (rd_data_o !== 32'(old400))
          $display("FAIL rd_before_wr: got %h want %h", rd_data_o, old400); else pass_cnt++;
      end
    end
    smp_valid_i = 1'b0;
    total_cnt++; if (state_o !== 2'd2 || wr_count_o !== 11'd500)
      $display("FAIL mid_count: got st=%0d cnt=%0d want 2 500", state_o, wr_count_o); else pass_cnt++;
    rstn = 1'b0;
    #2;
    $display("async reset mid-take: state=%0d count=%0d rdata=%h", state_o, wr_count_o, rd_data_o);
    total_cnt++; if (state_o !== 2'd0 || wr_count_o !== 11'd0 || rd_data_o !== 32'd0 ||
                     full_o !== 1'b0 || overrun_o !== 1'b0)
      $display("FAIL mid_reset: got st=%0d cnt=%0d rd=%h full=%b ovr=%b want all 0",
               state_o, wr_count_o, rd_data_o, full_o, overrun_o);
    else pass_cnt++;
    rec_en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    total_cnt++; if (state_o !== 2'd0) $display("FAIL post_reset_state: got %0d want 0", state_o); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      rd_word(i, d);
      total_cnt++;
      if (d !== 32'(ref_mem[i])) begin
        errs++;
        if (errs <= 4) $display("FAIL kept_mem[%0d]: got %h want %h", i, d, ref_mem[i]);
      end else pass_cnt++;
    end
    $display("post-reset readback of 500 words: %0d differences", errs);
  endtask

  initial begin
    test_reset();
    test_arm();
    test_trigger();
    test_neg_trigger();
    test_full_overrun();
    test_truncate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
